// File: rtl/issue_port_scheduler.sv
// rtl/issue_port_scheduler.sv - two-FU issue scheduler driving the issue queue pick-port readies
module issue_port_scheduler #(
    parameter int DATA_W = 8,
    parameter int LAT_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sched_en,
    input  logic              iq_out0_valid,
    input  logic [DATA_W-1:0] iq_out0_data,
    output logic              iq_out0_ready,
    input  logic              iq_out1_valid,
    input  logic [DATA_W-1:0] iq_out1_data,
    output logic              iq_out1_ready,
    output logic              fu0_issue_valid,
    output logic [DATA_W-1:0] fu0_issue_data,
    output logic              fu1_issue_valid,
    output logic [DATA_W-1:0] fu1_issue_data,
    output logic [1:0]        fu_done,
    output logic [1:0]        fu_busy,
    output logic [CNT_W-1:0]  issue_count,
    output logic              idle
);

    localparam logic [LAT_W:0] ONE = (LAT_W+1)'(1);

    logic [LAT_W:0]      cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                rr_q, rr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                v0_q, v1_q;
    logic [DATA_W-1:0]   d0_q, d1_q;

    logic                free0, free1, both_free;
    logic                iss0_v, iss1_v;
    logic [DATA_W-1:0]   iss0_d, iss1_d;

    function automatic logic [LAT_W:0] op_lat(input logic [DATA_W-1:0] d);
        return {1'b0, d[DATA_W-1 -: LAT_W]} + ONE;
    endfunction

    // An FU in its last busy cycle is already free so it can take a back-to-back op
    assign free0     = (cnt0_q == '0) || (cnt0_q == ONE);
    assign free1     = (cnt1_q == '0) || (cnt1_q == ONE);
    assign both_free = free0 & free1;

    assign iq_out0_ready = sched_en & iq_out0_valid & (free0 | free1);
    assign iq_out1_ready = iq_out0_ready & iq_out1_valid & both_free;

    always_comb begin
        iss0_v = 1'b0;
        iss1_v = 1'b0;
        iss0_d = iq_out0_data;
        iss1_d = iq_out0_data;
        if (iq_out0_ready) begin
            if (both_free) begin
                if (!rr_q) begin
                    iss0_v = 1'b1;
                    iss1_v = iq_out1_ready;
                    iss1_d = iq_out1_data;
                end else begin
                    iss1_v = 1'b1;
                    iss0_v = iq_out1_ready;
                    iss0_d = iq_out1_data;
                end
            end else if (free0) begin
                iss0_v = 1'b1;
            end else begin
                iss1_v = 1'b1;
            end
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (iss0_v)              cnt0_d = op_lat(iss0_d);
        else if (cnt0_q != '0)   cnt0_d = cnt0_q - ONE;
        if (iss1_v)              cnt1_d = op_lat(iss1_d);
        else if (cnt1_q != '0)   cnt1_d = cnt1_q - ONE;
        rr_d    = rr_q ^ (both_free & iq_out0_ready);
        count_d = count_q + CNT_W'(iq_out0_ready) + CNT_W'(iq_out1_ready);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            rr_q    <= 1'b0;
            count_q <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            v0_q    <= iss0_v;
            v1_q    <= iss1_v;
            if (iss0_v) d0_q <= iss0_d;
            if (iss1_v) d1_q <= iss1_d;
        end
    end

    assign fu0_issue_valid = v0_q;
    assign fu0_issue_data  = d0_q;
    assign fu1_issue_valid = v1_q;
    assign fu1_issue_data  = d1_q;
    assign fu_busy         = {cnt1_q != '0, cnt0_q != '0};
    assign fu_done         = {cnt1_q == ONE, cnt0_q == ONE};
    assign issue_count     = count_q;
    assign idle            = (cnt0_q == '0) && (cnt1_q == '0) && !iq_out0_valid && !iq_out1_valid;

endmodule

// File: doc/issue_port_scheduler.md
# issue_port_scheduler

Output-side scheduler for `issue_queue_2picker`. It drives the queue's `out0_ready`/`out1_ready` so that picked entries go only to free functional units, and steers up to two entries per cycle onto two non-pipelined FUs (FU0, FU1). It tracks each FU's occupancy with a per-FU latency counter and reports completions and an issue count. It sits between the issue queue's two pick ports and the execution FUs.

## Interface
- `DATA_W`, 8, entry width; matches the queue's data width.
- `LAT_W`, 2, width of the latency field at `data[DATA_W-1 -: LAT_W]`; op latency L = field + 1.
- `CNT_W`, 16, width of `issue_count`.

Ports:
- `sys_clk`  in  1  clock; all state updates on the rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `sched_en`  in  1  enables issuing; when 0, both readies are 0.
- `iq_out0_valid`  in  1  queue pick port 0 valid (oldest entry).
- `iq_out0_data`  in  DATA_W  queue pick port 0 data.
- `iq_out0_ready`  out  1  to queue `out0_ready`.
- `iq_out1_valid`  in  1  queue pick port 1 valid (second-oldest entry).
- `iq_out1_data`  in  DATA_W  queue pick port 1 data.
- `iq_out1_ready`  out  1  to queue `out1_ready`.
- `fu0_issue_valid`  out  1  registered one-cycle issue pulse to FU0.
- `fu0_issue_data`  out  DATA_W  registered entry for FU0.
- `fu1_issue_valid`  out  1  same, FU1.
- `fu1_issue_data`  out  DATA_W  same, FU1.
- `fu_done`  out  2  bit k high while FU k is in its final busy cycle.
- `fu_busy`  out  2  bit k = (cnt_k != 0).
- `issue_count`  out  CNT_W  total handshakes since reset, wraps.
- `idle`  out  1  both cnt_k == 0 and neither `iq_outN_valid` is high.

## Operation
- **Per-FU state.** Down-counter `cnt_k`, width LAT_W+1.
  - Reset value 0.
  - Loaded with L on issue to FU k.
  - Otherwise decrements while nonzero.
- **FU free condition.** `free_k` = (cnt_k == 0) or (cnt_k == 1). This allows back-to-back issue into an FU in its completion cycle.
- **Ready rules (combinational).**
  - `iq_out0_ready` = `sched_en` & `iq_out0_valid` & (free_0 | free_1).
  - `iq_out1_ready` = `iq_out0_ready` & `iq_out1_valid` & free_0 & free_1.
  - Port 1 never pops without port 0. This preserves the queue's in-order pop rule.
- **Steering.**
  - Both FUs free: port 0 goes to FU[rr] and port 1 goes to FU[~rr].
  - Exactly one FU free: port 0 goes to that FU.
- **Round-robin bit `rr`.**
  - Reset value 0.
  - Toggles at the edge ending any cycle where both FUs were free and at least one handshake occurred.
  - Otherwise holds.
- **Registered issue outputs.** `fuk_issue_valid` and `fuk_issue_data` are registered from that cycle's handshake.
  - Valid is high for exactly one cycle.
  - Data holds its last value when valid is low.
- **Completion.** `fu_done[k]` = (cnt_k == 1), decoded directly from the register.
- **Issue count.** `issue_count` += number of handshakes in the cycle (0, 1 or 2), modulo 2^CNT_W.
- **Reset.** Asserting `sys_rst_n` low immediately clears all registers, including mid-operation:
  - cnt_k, rr, issue_count and the fu_issue regs go to 0.
  - Outputs become: readies 0 (once `sched_en`/valid inputs are considered), `fu_busy`=0, `fu_done`=0, `issue_count`=0, `fu*_issue_valid`=0, `fu*_issue_data`=0.
  - `idle` follows the valid inputs.
- **Precedence on a cycle where `cnt_k` == 1 and a new issue to FU k occurs.** The load of L wins over the decrement.

## Timing
- Handshake in cycle t: `fuk_issue_valid` is high in cycle t+1, and `cnt_k` = L from t+1.
- `fu_done[k]` is high in cycle t+L. FU k accepts a new handshake in cycle t+L.
- Latency-1 ops (field 0) can therefore issue to the same FU every cycle.
- Readies have zero-cycle combinational dependence on the valid inputs and `sched_en`. There is no combinational path from the `iq_*_data` latency field to the readies.
- Throughput:
  - Maximum 2 entries per cycle when both FUs are free.
  - 1 per cycle when one FU is free.
  - 0 when both FUs are busy beyond their last cycle.

## Test plan
1. **Dual issue after reset.** `sched_en`=1; port 0 = 0x11 and port 1 = 0x22 valid in the same cycle → both readies 1. Next cycle: `fu0_issue_valid` with 0x11, `fu1_issue_valid` with 0x22, `issue_count`=2, rr=1. A second pair 0x33/0x44 → 0x33 goes to FU1 and 0x44 to FU0.
2. **Latency tracking.** Issue 0xC0 (L=4) alone at cycle t → `fu_busy[rr]` is high for cycles t+1..t+4, `fu_done` is high only in t+4, and a new entry is accepted in t+4.
3. **Single free FU.** FU0 is busy with 0xC0 and both ports are valid with 0x05/0x06 → `iq_out0_ready`=1, `iq_out1_ready`=0, 0x05 goes to FU1, and 0x06 is popped in a later cycle.
4. **Gating.** `sched_en`=0 with both ports valid for 3 cycles → both readies stay 0, `issue_count` is unchanged, and `idle`=0.
5. **Async reset mid-op.** During a latency-4 op, pull `sys_rst_n` low between clock edges → `fu_busy`, `issue_count` and the issue pulses read 0 before the next edge. After release, issuing resumes with rr=0.
6. **Counter wrap.** With `CNT_W`=4, 16 issues return `issue_count` to 0. A dual issue at count 15 yields 1.
